// File: rtl/led_pwm_fader.sv
// Per-channel LED fader: synchronized on/off requests ramp a saturating
// brightness level that is rendered as PWM with selectable output polarity.
module led_pwm_fader #(
  parameter int CHANNELS       = 3,
  parameter int PWM_BITS       = 8,
  parameter int STEP_DIV       = 4096,
  parameter bit ACTIVE_LOW_OUT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          led_in,
  input  logic                         enable,
  output logic [CHANNELS-1:0]          led_out,
  output logic [CHANNELS*PWM_BITS-1:0] level,
  output logic                         busy
);

  localparam int S_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [S_W-1:0]      S_LAST  = S_W'(STEP_DIV - 1);
  localparam logic [S_W-1:0]      S_ONE   = S_W'(1);
  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] P_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
  localparam logic [CHANNELS-1:0] POL     = {CHANNELS{ACTIVE_LOW_OUT}};

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] tgt_q;
  logic [S_W-1:0]      s_q, s_d;
  logic [PWM_BITS-1:0] p_q, p_d;
  logic [CHANNELS-1:0] led_out_q, led_out_d;
  logic [CHANNELS-1:0] on_w;
  logic [CHANNELS-1:0] busy_w;
  logic                step_tick;

  // led_in may come from switches: plain two-flop synchronizer per bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      tgt_q   <= '0;
    end else begin
      sync1_q <= led_in;
      tgt_q   <= sync1_q;
    end
  end

  assign step_tick = enable && (s_q == S_LAST);

  always_comb begin
    s_d = s_q + S_ONE;
    if (!enable || (s_q == S_LAST)) begin
      s_d = '0;
    end
  end

  // PWM period is MAX clocks, so a level of MAX is lit on every cycle.
  assign p_d = (p_q == P_LAST) ? '0 : (p_q + LVL_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [PWM_BITS-1:0] lvl_q, lvl_d;

      // Disable wins over a coincident tick; ramps saturate at both ends.
      always_comb begin
        lvl_d = lvl_q;
        if (!enable) begin
          lvl_d = '0;
        end else if (step_tick) begin
          if (tgt_q[gi] && (lvl_q != MAX)) begin
            lvl_d = lvl_q + LVL_ONE;
          end else if (!tgt_q[gi] && (lvl_q != '0)) begin
            lvl_d = lvl_q - LVL_ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lvl_q <= '0;
        end else begin
          lvl_q <= lvl_d;
        end
      end

      assign on_w[gi]   = (lvl_q > p_q);
      assign busy_w[gi] = tgt_q[gi] ? (lvl_q != MAX) : (lvl_q != '0);
      assign level[gi*PWM_BITS +: PWM_BITS] = lvl_q;
    end
  endgenerate

  assign led_out_d = on_w ^ POL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out_q <= POL;
    end else begin
      led_out_q <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign busy    = |busy_w;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: random and directed stimulus against a
// cycle-level arithmetic reference model plus directed fade/duty checks.
module tb_led_pwm_fader;

  localparam int CH       = 3;
  localparam int PB       = 4;
  localparam int DIV      = 2;
  localparam int MAXV     = 15;
  localparam int SLOW_DIV = 64;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            enable   = 1'b0;
  logic            s_enable = 1'b1;
  logic [CH-1:0]   led_in   = '0;
  logic [CH-1:0]   s_led_in = '0;
  logic [CH-1:0]   led_out, s_led_out;
  logic [CH*PB-1:0] level, s_level;
  logic            busy, s_busy;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(DIV), .ACTIVE_LOW_OUT(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .enable(enable),
    .led_out(led_out), .level(level), .busy(busy)
  );

  // Slow-stepping copy so a mid-scale level stays put for a whole PWM period.
  led_pwm_fader #(
    .CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(SLOW_DIV), .ACTIVE_LOW_OUT(1'b1)
  ) u_slow (
    .clk(clk), .reset_n(reset_n), .led_in(s_led_in), .enable(s_enable),
    .led_out(s_led_out), .level(s_level), .busy(s_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: levels as integers, tick from a count of enabled
  // cycles, PWM phase from cycles since reset, request delay as a queue.
  int            m_lvl [CH];
  int            m_run;
  int            m_cyc;
  logic [CH-1:0] m_q [$];
  logic [CH-1:0] m_out;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_lvl[c] = 0;
    m_run = 0;
    m_cyc = 0;
    m_q.delete();
    m_q.push_back('0);
    m_q.push_back('0);
    m_out = '1;
  endtask

  task automatic model_step();
    logic [CH-1:0] t;
    bit tick;
    t = m_q[0];
    tick = enable && ((m_run % DIV) == DIV - 1);
    for (int c = 0; c < CH; c++) m_out[c] = !(m_lvl[c] > (m_cyc % MAXV));
    for (int c = 0; c < CH; c++) begin
      if (!enable) m_lvl[c] = 0;
      else if (tick) begin
        if (t[c]) m_lvl[c] = (m_lvl[c] < MAXV) ? m_lvl[c] + 1 : MAXV;
        else      m_lvl[c] = (m_lvl[c] > 0)    ? m_lvl[c] - 1 : 0;
      end
    end
    m_run = enable ? m_run + 1 : 0;
    m_cyc++;
    void'(m_q.pop_front());
    m_q.push_back(led_in);
  endtask

  function automatic logic [CH*PB-1:0] exp_level();
    logic [CH*PB-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[c*PB +: PB] = PB'(m_lvl[c]);
    return v;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = 1'b0;
    for (int c = 0; c < CH; c++)
      b = b | (m_q[0][c] ? (m_lvl[c] != MAXV) : (m_lvl[c] != 0));
    return b;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("m_level",   level,   exp_level());
        chk("m_led_out", led_out, m_out);
        chk("m_busy",    busy,    exp_busy());
      end
    end
  end

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) led_in = CH'($urandom);
      enable = ($urandom_range(0, 15) != 0);
    end
  endtask

  int            n, cnt, peak, rises, prv, cur;
  bit            down;
  logic [CH*PB-1:0] prev;

  initial begin
    repeat (3) @(negedge clk);
    chk("init_led_out", led_out, 3'b111);
    chk("init_level",   level,   0);
    #2 reset_n = 1'b1;
    enable = 1'b1;
    random_phase(300);

    // Reset asserted mid-run takes effect without a clock edge.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_led_out", led_out, 3'b111);
    chk("rst_level",   level,   0);
    chk("rst_busy",    busy,    0);
    chk("rst_s_level", s_level, 0);
    repeat (2) @(negedge clk);
    led_in = '0;
    enable = 1'b1;
    #2 reset_n = 1'b1;
    s_led_in = 3'b010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_led_out", led_out, 3'b111);
      chk("idle_level",   level,   0);
      chk("idle_busy",    busy,    0);
    end

    // Full fade-up of channel 0.
    led_in = 3'b001;
    @(negedge clk);
    chk("fade_busy_early", busy, 0);
    @(negedge clk);
    chk("fade_busy_on", busy, 1);
    n = 2;
    while (level[PB-1:0] != 4'd15 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("fade_up_time", (n == 31 || n == 32), 1);
    chk("fade_busy_off", busy, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("fade_full_on", led_out[0], 0);
    end

    // Duty at level 5 on the slow instance.
    n = 0;
    while (s_level[2*PB-1:PB] != 4'd5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("duty_reached", s_level[2*PB-1:PB], 5);
    @(negedge clk);
    cnt = 0;
    prv = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (s_led_out[1] == 1'b0) cnt++;
      if (s_led_out[0] == 1'b1) prv++;
    end
    chk("duty_l5_lit",   cnt, 5);
    chk("duty_l0_dark",  prv, 15);
    chk("duty_hold",     s_level[2*PB-1:PB], 5);
    chk("duty_busy",     s_busy, 1);

    // Reversal of channel 2, released so that it peaks at 9.
    led_in = 3'b101;
    n = 0;
    while (level[3*PB-1:2*PB] != 4'd8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rev_reach8", level[3*PB-1:2*PB], 8);
    led_in = 3'b001;
    prv = 8; peak = 8; rises = 0; down = 1'b0; n = 0;
    while (level[3*PB-1:2*PB] != 4'd0 && n < 100) begin
      @(negedge clk);
      n++;
      cur = int'(level[3*PB-1:2*PB]);
      if (cur > peak) peak = cur;
      if (cur < prv) down = 1'b1;
      else if (cur > prv && down) rises++;
      prv = cur;
    end
    chk("rev_peak",   peak, 9);
    chk("rev_rebound", rises, 0);
    chk("rev_end",    level[3*PB-1:2*PB], 0);
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("rev_dark", led_out[2], 1);
    end
    chk("rev_busy", busy, 0);

    // Enable drop on a tick cycle while all channels ramp.
    led_in = 3'b000;
    n = 0;
    while (level != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("en_all_zero", level, 0);
    led_in = 3'b111;
    prev = level;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (level == prev && n < 10);
    chk("en_tick_seen", (level != prev), 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_drop_level", level, 0);
    @(negedge clk);
    chk("en_drop_out", led_out, 3'b111);
    enable = 1'b1;
    @(negedge clk);
    chk("en_restart_hold", level, 0);
    @(negedge clk);
    chk("en_restart_step", level, 12'h111);

    // Saturation at MAX on every channel.
    n = 0;
    while (level != 12'hFFF && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_reached", level, 12'hFFF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("sat_level",   level,   12'hFFF);
      chk("sat_busy",    busy,    0);
      chk("sat_led_out", led_out, 3'b000);
    end

    random_phase(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream LED output stage sitting between the LED pattern generator and the board LED pins. It takes one on/off request bit per channel and ramps each channel's brightness linearly up or down at a fixed step rate. Each brightness level is rendered as a PWM waveform, so pattern changes appear as soft fades instead of hard switches. Output polarity is selectable, so the board's inversion of the LED pins lives inside this block.

## Interface

Parameters:
- CHANNELS, 3: number of LED channels.
- PWM_BITS, 8: brightness resolution. MAX = 2^PWM_BITS-1. Legal range 2..12.
- STEP_DIV, 4096: clocks per brightness step. Must be ≥1.
- ACTIVE_LOW_OUT, 1: 1 means a lit LED drives its led_out bit to 0.

Ports:
- clk  in  1  system clock; everything is in this single domain.
- reset_n  in  1  reset; asynchronous and active-low.
- led_in  in  CHANNELS  per-channel request, 1 = lit. May come from switches, so it is synchronized.
- enable  in  1  1 = fading active; 0 = all channels forced dark.
- led_out  out  CHANNELS  registered PWM drive to the pins, polarity per ACTIVE_LOW_OUT.
- level  out  CHANNELS*PWM_BITS  current brightness per channel. Channel c occupies bits [c*PWM_BITS +: PWM_BITS].
- busy  out  1  1 while any channel's level differs from its target endpoint.

## Operation

- Input synchronizer:
  - two flops per led_in bit.
  - tgt[c] is the second flop.
- Step prescaler:
  - counter S runs 0..STEP_DIV-1 and wraps to 0.
  - step_tick = (S == STEP_DIV-1) && enable.
  - enable=0 holds S at 0.
  - STEP_DIV=1 gives a tick every enabled cycle.
- Level update, per channel L[c], on step_tick only:
  - tgt=1 and L<MAX: L+1.
  - tgt=0 and L>0: L-1.
  - otherwise L holds.
  - L saturates at 0 and MAX; it never wraps.
- A request reversal mid-ramp reverses direction at the next tick, starting from the current L. There is no restart.
- enable=0: every L is cleared to 0 in the same cycle. enable takes priority over a coincident step_tick.
- PWM counter P:
  - free-running 0..MAX-1, wrapping to 0, so the period is MAX clocks.
  - runs regardless of enable.
- Compare: on[c] = (L[c] > P).
  - L=0 is never lit.
  - L=MAX is lit every cycle.
  - duty = L/MAX.
- led_out[c] is registered as on[c] XOR ACTIVE_LOW_OUT.
- busy = OR over c of ((tgt[c] && L[c]!=MAX) || (!tgt[c] && L[c]!=0)). It is decoded combinationally from registers.
- level is driven directly from the L registers.

## Timing

- Reset (asynchronous assert) clears:
  - both sync flops, S, P and all L to 0.
  - led_out to all ACTIVE_LOW_OUT (LEDs dark).
  - busy to 0.
- Reset release is used synchronously; counting starts on the first clk edge with reset_n=1.
- Reset mid-ramp returns the block to the reset state immediately, with no completion of the step in flight.
- Latency:
  - led_in to tgt: 2 clocks.
  - tgt to the first L change: the next step_tick, at most STEP_DIV clocks.
  - L/P to led_out: 1 clock.
- Full ramp 0→MAX takes exactly MAX step_ticks = MAX*STEP_DIV clocks with enable held at 1. MAX→0 takes the same.
- busy follows tgt and L with no extra delay.
- busy falls in the cycle after the final saturating tick.
- A level change takes effect in the PWM compare from the cycle after the tick. There is no period-boundary alignment.

## Test plan

Bench parameters: CHANNELS=3, PWM_BITS=4 (MAX=15), STEP_DIV=2, ACTIVE_LOW_OUT=1.

- **Reset values:** assert reset_n=0 mid-run → same cycle led_out=3'b111, level=0, busy=0. After release with led_in=0, all outputs stay unchanged.
- **Full fade-up:**
  - stimulus: enable=1, led_in=3'b001.
  - busy=1 from 2 clocks after led_in.
  - L[0] counts 1..15, one step every 2 clocks, and reaches 15 in 30 clocks (plus sync and prescaler phase).
  - at L[0]=15, led_out[0] is 0 every cycle and busy drops.
- **PWM duty:** hold L[1]=5 (stop the ramp by releasing led_in at L=5, then re-request on a tick boundary, or force it) → over a 15-clock PWM period led_out[1] is 0 for exactly 5 clocks.
- **Reversal:** led_in[2] goes 1 → 0 when L[2]=9 → L[2] continues 9,8,...,0 with no overshoot. At L=0, led_out[2] is 1 constantly and busy=0.
- **enable priority:** drop enable on a step_tick cycle while all three channels ramp → the next cycle all L=0, S=0 and led_out=3'b111. Raising enable again restarts the ramps from 0.
- **Saturation:** hold led_in=3'b111 for 100 clocks → every L stays at 15 (never wraps to 0) and busy stays 0.
